// File: rtl/readout_tx_meas_sequencer.sv
// Readout sequencer: tone pulse, RX integration window, bounded decision wait, held response.
// Request-to-request >= PULSE+INTEGRATE+3 cycles; response held until result_ready_in, requests ignored when busy.
module readout_tx_meas_sequencer #(
    parameter int PULSE_CYCLES        = 4,
    parameter int INTEGRATE_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES      = 4,
    parameter int QUBIT_ID_WIDTH      = 5,
    parameter int CYCLE_COUNTER_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      meas_req_in,
    input  logic [QUBIT_ID_WIDTH-1:0] meas_qubit_id_in,
    output logic                      meas_req_ready_out,
    output logic                      tx_pulse_en_out,
    output logic [QUBIT_ID_WIDTH-1:0] tx_qubit_id_out,
    output logic                      start_count_out,
    output logic                      finish_count_out,
    input  logic                      valid_meas_result_in,
    input  logic                      meas_result_in,
    output logic                      result_valid_out,
    output logic                      result_out,
    output logic [QUBIT_ID_WIDTH-1:0] result_qubit_id_out,
    output logic                      result_timeout_out,
    input  logic                      result_ready_in
);

    localparam int CW = CYCLE_COUNTER_WIDTH;

    // Counters hold "cycles remaining after this one", so entry loads N-1.
    localparam logic [CW-1:0] PULSE_LOAD     = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] INTEGRATE_LOAD = CW'(INTEGRATE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_INTEGRATE,
        S_WAIT_RESULT,
        S_RESPOND
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [QUBIT_ID_WIDTH-1:0] id_q, id_d;
    logic                      result_q, result_d;
    logic                      timeout_q, timeout_d;

    logic                      ready_q, ready_d;
    logic                      tx_en_q, tx_en_d;
    logic [QUBIT_ID_WIDTH-1:0] tx_id_q, tx_id_d;
    logic                      start_q, start_d;
    logic                      finish_q, finish_d;
    logic                      res_vld_q, res_vld_d;
    logic [QUBIT_ID_WIDTH-1:0] res_id_q, res_id_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        result_d  = result_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (meas_req_in) begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LOAD;
                    id_d    = meas_qubit_id_in;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_INTEGRATE;
                    cnt_d   = INTEGRATE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INTEGRATE: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT_RESULT;
                    cnt_d   = TIMEOUT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_RESULT: begin
                // A decision on the last wait cycle beats the timeout.
                if (valid_meas_result_in) begin
                    state_d   = S_RESPOND;
                    result_d  = meas_result_in;
                    timeout_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d   = S_RESPOND;
                    result_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESPOND: begin
                if (result_ready_in) begin
                    state_d   = S_IDLE;
                    result_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        ready_d   = (state_d == S_IDLE);
        tx_en_d   = (state_d == S_PULSE);
        tx_id_d   = (state_d == S_PULSE) ? id_d : '0;
        start_d   = (state_d == S_INTEGRATE) && (state_q != S_INTEGRATE);
        finish_d  = (state_d == S_INTEGRATE) && (cnt_d == '0);
        res_vld_d = (state_d == S_RESPOND);
        res_id_d  = (state_d == S_RESPOND) ? id_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            id_q      <= '0;
            result_q  <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
            tx_en_q   <= 1'b0;
            tx_id_q   <= '0;
            start_q   <= 1'b0;
            finish_q  <= 1'b0;
            res_vld_q <= 1'b0;
            res_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            ready_q   <= ready_d;
            tx_en_q   <= tx_en_d;
            tx_id_q   <= tx_id_d;
            start_q   <= start_d;
            finish_q  <= finish_d;
            res_vld_q <= res_vld_d;
            res_id_q  <= res_id_d;
        end
    end

    assign meas_req_ready_out  = ready_q;
    assign tx_pulse_en_out     = tx_en_q;
    assign tx_qubit_id_out     = tx_id_q;
    assign start_count_out     = start_q;
    assign finish_count_out    = finish_q;
    assign result_valid_out    = res_vld_q;
    assign result_out          = result_q;
    assign result_qubit_id_out = res_id_q;
    assign result_timeout_out  = timeout_q;

endmodule

// File: tb/tb_readout_tx_meas_sequencer.sv
// Directed bench for readout_tx_meas_sequencer with a response scoreboard.
module tb_readout_tx_meas_sequencer;

    localparam int P  = 4;
    localparam int I  = 8;
    localparam int T  = 4;
    localparam int QW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          meas_req_in;
    logic [QW-1:0] meas_qubit_id_in;
    logic          meas_req_ready_out;
    logic          tx_pulse_en_out;
    logic [QW-1:0] tx_qubit_id_out;
    logic          start_count_out;
    logic          finish_count_out;
    logic          valid_meas_result_in;
    logic          meas_result_in;
    logic          result_valid_out;
    logic          result_out;
    logic [QW-1:0] result_qubit_id_out;
    logic          result_timeout_out;
    logic          result_ready_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [QW-1:0] id;
        logic          res;
        logic          to;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    readout_tx_meas_sequencer #(
        .PULSE_CYCLES(P), .INTEGRATE_CYCLES(I), .TIMEOUT_CYCLES(T),
        .QUBIT_ID_WIDTH(QW), .CYCLE_COUNTER_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .meas_req_in(meas_req_in), .meas_qubit_id_in(meas_qubit_id_in),
        .meas_req_ready_out(meas_req_ready_out),
        .tx_pulse_en_out(tx_pulse_en_out), .tx_qubit_id_out(tx_qubit_id_out),
        .start_count_out(start_count_out), .finish_count_out(finish_count_out),
        .valid_meas_result_in(valid_meas_result_in), .meas_result_in(meas_result_in),
        .result_valid_out(result_valid_out), .result_out(result_out),
        .result_qubit_id_out(result_qubit_id_out), .result_timeout_out(result_timeout_out),
        .result_ready_in(result_ready_in)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},  {31'd0, meas_req_ready_out}, 32'd1);
        check({tag, "_txen"},   {31'd0, tx_pulse_en_out},    32'd0);
        check({tag, "_txid"},   {27'd0, tx_qubit_id_out},    32'd0);
        check({tag, "_start"},  {31'd0, start_count_out},    32'd0);
        check({tag, "_finish"}, {31'd0, finish_count_out},   32'd0);
        check({tag, "_rvld"},   {31'd0, result_valid_out},   32'd0);
        check({tag, "_res"},    {31'd0, result_out},         32'd0);
        check({tag, "_rid"},    {27'd0, result_qubit_id_out}, 32'd0);
        check({tag, "_to"},     {31'd0, result_timeout_out}, 32'd0);
    endtask

    task automatic check_resp(input string tag, input exp_t e);
        check({tag, "_rvld"}, {31'd0, result_valid_out},    32'd1);
        check({tag, "_res"},  {31'd0, result_out},          {31'd0, e.res});
        check({tag, "_rid"},  {27'd0, result_qubit_id_out}, {27'd0, e.id});
        check({tag, "_to"},   {31'd0, result_timeout_out},  {31'd0, e.to});
        check({tag, "_rdy"},  {31'd0, meas_req_ready_out},  32'd0);
    endtask

    // decide: WAIT_RESULT cycle (1..T) on which the decision is driven, 0 = never.
    // hold: cycles result_ready_in stays low in RESPOND; a second request is made during it.
    task automatic do_meas(input string tag, input logic [QW-1:0] id, input int decide,
                           input logic res, input logic stray, input int hold);
        exp_t e;
        exp_t got;
        bit   done;
        result_ready_in = (hold == 0);
        check({tag, "_acc_rdy"}, {31'd0, meas_req_ready_out}, 32'd1);
        meas_req_in      = 1'b1;
        meas_qubit_id_in = id;
        e.id  = id;
        e.res = (decide == 0) ? 1'b0 : res;
        e.to  = (decide == 0);
        sb.push_back(e);
        tick();
        meas_req_in      = 1'b0;
        meas_qubit_id_in = ~id;

        for (int i = 1; i <= P; i++) begin
            check({tag, "_p_en"},    {31'd0, tx_pulse_en_out},    32'd1);
            check({tag, "_p_id"},    {27'd0, tx_qubit_id_out},    {27'd0, id});
            check({tag, "_p_rdy"},   {31'd0, meas_req_ready_out}, 32'd0);
            check({tag, "_p_start"}, {31'd0, start_count_out},    32'd0);
            if (stray && i == 2) begin
                valid_meas_result_in = 1'b1;
                meas_result_in       = ~res;
            end
            tick();
            valid_meas_result_in = 1'b0;
            meas_result_in       = 1'b0;
        end

        for (int i = 1; i <= I; i++) begin
            check({tag, "_i_en"},     {31'd0, tx_pulse_en_out},  32'd0);
            check({tag, "_i_start"},  {31'd0, start_count_out},  {31'd0, (i == 1)});
            check({tag, "_i_finish"}, {31'd0, finish_count_out}, {31'd0, (i == I)});
            check({tag, "_i_rvld"},   {31'd0, result_valid_out}, 32'd0);
            tick();
        end

        done = 1'b0;
        for (int w = 1; w <= T && !done; w++) begin
            check({tag, "_w_rvld"},   {31'd0, result_valid_out}, 32'd0);
            check({tag, "_w_finish"}, {31'd0, finish_count_out}, 32'd0);
            if (w == decide) begin
                valid_meas_result_in = 1'b1;
                meas_result_in       = res;
                done = 1'b1;
            end
            tick();
            valid_meas_result_in = 1'b0;
            meas_result_in       = 1'b0;
        end

        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            got = e;
        end else begin
            got = sb.pop_front();
        end

        for (int k = 0; k < hold; k++) begin
            check_resp({tag, "_hold"}, got);
            meas_req_in      = (k == 3);
            meas_qubit_id_in = 5'd30;
            tick();
        end
        meas_req_in     = 1'b0;
        result_ready_in = 1'b1;
        check_resp({tag, "_xfer"}, got);
        tick();
        check({tag, "_post_rvld"}, {31'd0, result_valid_out},   32'd0);
        check({tag, "_post_rdy"},  {31'd0, meas_req_ready_out}, 32'd1);
        check({tag, "_post_txen"}, {31'd0, tx_pulse_en_out},    32'd0);
    endtask

    initial begin
        rst = 1'b1;
        meas_req_in = 1'b0;
        meas_qubit_id_in = '0;
        valid_meas_result_in = 1'b0;
        meas_result_in = 1'b0;
        result_ready_in = 1'b1;

        tick();
        meas_req_in = 1'b1;
        tick();
        check_idle("rst");
        meas_req_in = 1'b0;
        rst = 1'b0;
        tick();
        check_idle("rst_rel");

        do_meas("nominal",  5'd7,  1, 1'b1, 1'b0, 0);
        do_meas("b2b",      5'd3,  2, 1'b0, 1'b0, 0);
        do_meas("timeout",  5'd12, 0, 1'b1, 1'b0, 0);
        do_meas("to_edge",  5'd21, T, 1'b1, 1'b0, 0);
        do_meas("bp",       5'd9,  1, 1'b1, 1'b0, 10);

        // The request made during backpressure must not have been queued.
        for (int k = 0; k < 4; k++) begin
            check_idle("bp_noq");
            tick();
        end

        do_meas("stray",    5'd5,  3, 1'b1, 1'b1, 0);

        // Reset on INTEGRATE cycle 3.
        meas_req_in = 1'b1;
        meas_qubit_id_in = 5'd17;
        tick();
        meas_req_in = 1'b0;
        for (int i = 0; i < P; i++) tick();
        check("mid_start", {31'd0, start_count_out}, 32'd1);
        tick();
        tick();
        check("mid_c3_finish", {31'd0, finish_count_out}, 32'd0);
        rst = 1'b1;
        tick();
        check_idle("mid_rst");
        tick();
        check_idle("mid_rst2");
        rst = 1'b0;
        for (int k = 0; k < I + T + 2; k++) begin
            tick();
            check_idle("mid_after");
        end

        do_meas("post_rst", 5'd31, 1, 1'b0, 1'b0, 0);

        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/readout_tx_meas_sequencer.md
READOUT_TX_MEAS_SEQUENCER -- requirements
Module: readout_tx_meas_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  PULSE_CYCLES, 4, readout tone duration in cycles, legal range 1..2^CYCLE_COUNTER_WIDTH-1.
  INTEGRATE_CYCLES, 8, bin-count integration window in cycles, legal range 1..2^CYCLE_COUNTER_WIDTH-1.
  TIMEOUT_CYCLES, 4, maximum wait for a decision in cycles, legal range 1..2^CYCLE_COUNTER_WIDTH-1.
  QUBIT_ID_WIDTH, 5, qubit index width.
  CYCLE_COUNTER_WIDTH, 16, internal cycle-counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  single clock; all logic is on its rising edge.
  rst  in  1  synchronous, active-high reset.
  meas_req_in  in  1  measurement request.
  meas_qubit_id_in  in  QUBIT_ID_WIDTH  qubit to measure.
  meas_req_ready_out  out  1  request accepted when this and meas_req_in are both high.
  tx_pulse_en_out  out  1  readout tone enable.
  tx_qubit_id_out  out  QUBIT_ID_WIDTH  qubit being read out.
  start_count_out  out  1  one-cycle pulse that clears and starts the RX bin counter.
  finish_count_out  out  1  one-cycle pulse to the RX decision logic.
  valid_meas_result_in  in  1  decision valid, from the RX decision logic.
  meas_result_in  in  1  decided state.
  result_valid_out  out  1  response valid.
  result_out  out  1  measured state.
  result_qubit_id_out  out  QUBIT_ID_WIDTH  qubit the response belongs to.
  result_timeout_out  out  1  no decision arrived within the timeout.
  result_ready_in  in  1  consumer accepts the response.

Function
REQ-003 The block SHALL implement an FSM with the states IDLE, PULSE, INTEGRATE, WAIT_RESULT and RESPOND, and every output SHALL be registered.
REQ-004 meas_req_ready_out SHALL be 1 only in IDLE; a request made while the block is not ready SHALL be ignored and SHALL NOT be queued.
REQ-005 On acceptance, the block SHALL latch meas_qubit_id_in and enter PULSE on the next cycle.
REQ-006 In PULSE, tx_pulse_en_out SHALL be 1 for exactly PULSE_CYCLES consecutive cycles and tx_qubit_id_out SHALL equal the latched ID; the block SHALL then enter INTEGRATE.
REQ-007 In INTEGRATE, the block SHALL stay exactly INTEGRATE_CYCLES cycles, assert start_count_out on the first INTEGRATE cycle only, and assert finish_count_out on the last INTEGRATE cycle only.
REQ-008 When INTEGRATE_CYCLES=1, start_count_out and finish_count_out SHALL both be 1 in that single cycle.
REQ-009 WAIT_RESULT SHALL last at most TIMEOUT_CYCLES cycles.
  If valid_meas_result_in is 1 in any WAIT_RESULT cycle, the block SHALL capture meas_result_in, set result_timeout_out=0 and enter RESPOND.
  If valid_meas_result_in does not assert within TIMEOUT_CYCLES cycles, the block SHALL set result_out=0 and result_timeout_out=1 and enter RESPOND.
REQ-010 When valid_meas_result_in asserts on the final WAIT_RESULT cycle, the valid result SHALL take priority over the timeout.
REQ-011 valid_meas_result_in SHALL be ignored in every state other than WAIT_RESULT.
REQ-012 In RESPOND, result_valid_out SHALL be 1 and result_out, result_qubit_id_out and result_timeout_out SHALL be held stable until result_ready_in=1. The transfer SHALL complete on that cycle, and the next cycle SHALL be IDLE with result_valid_out=0.
REQ-013 The minimum request-to-request spacing SHALL be PULSE_CYCLES+INTEGRATE_CYCLES+3 cycles, which occurs when the decision arrives in the first WAIT_RESULT cycle and result_ready_in is held at 1.
REQ-014 Cycle counters SHALL reload at each state entry and SHALL never wrap within a state.

Reset
REQ-015 While rst=1, the FSM SHALL be forced to IDLE, every output except meas_req_ready_out SHALL be 0, and meas_req_ready_out SHALL be 1 from the first cycle after rst deasserts.
REQ-016 Reset asserted mid-operation SHALL abort the measurement with no finish_count_out pulse and no response, and any held response SHALL be dropped.
REQ-017 rst SHALL take priority over every other input.

Verification
REQ-018 Nominal case: defaults, request for ID 7, decision returns 1 on the first WAIT_RESULT cycle, ready held at 1 -> tx_pulse_en_out is high for 4 cycles, start_count_out pulses on cycle 1 of INTEGRATE, finish_count_out pulses on cycle 8 of INTEGRATE, and result_valid_out=1 with result_out=1, result_qubit_id_out=7 and result_timeout_out=0, then the block is ready again.
REQ-019 Timeout: valid_meas_result_in is never asserted -> after exactly 4 WAIT_RESULT cycles, result_valid_out=1, result_out=0 and result_timeout_out=1.
REQ-020 Timeout boundary: valid_meas_result_in=1 with meas_result_in=1 on WAIT_RESULT cycle 4 -> result_out=1 and result_timeout_out=0.
REQ-021 Backpressure: result_ready_in is held at 0 for 10 cycles, and a second request is made during that time -> outputs stay stable, the second request is ignored, and the block returns to IDLE the cycle after ready=1.
REQ-022 Reset mid-operation: rst=1 on INTEGRATE cycle 3 -> no finish_count_out pulse, all outputs 0, and meas_req_ready_out=1 after rst deasserts.
REQ-023 Stray result: valid_meas_result_in pulsed during PULSE -> the pulse is ignored and the response reflects only the decision in WAIT_RESULT.
